motor_speed_ctrl: RTL and testbench
===================================

Name: motor_speed_ctrl

Overview:
Closed-loop speed controller for one drive motor. It consumes the 8-bit speed samples produced by the encoder decode/pulse-measurement chain and sequences each update through a sample/compute/apply state machine. It drives a saturating proportional duty register into an internal PWM generator, and shuts the motor down on stall detection. It sits between the motor processor's pulse_data output and the H-bridge enable pin.

Parameters:
KP_SHIFT, 2, proportional gain as a right shift: delta = error >>> KP_SHIFT
SAMPLE_TIMEOUT, 50000, clk_sys cycles to wait for meas_valid before treating the sample as speed 0
STALL_DUTY, 192, duty at or above which a zero-speed sample counts toward stall
STALL_COUNT, 8, consecutive qualifying samples that raise stall_fault

Ports:
clk_sys  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  controller run enable; low forces IDLE and clears the fault
target_speed  input  8  requested speed, same units as meas_speed; 0 means stop
meas_speed  input  8  measured speed from the pulse-measurement block
meas_valid  input  1  single-cycle strobe; meas_speed is valid in this cycle
duty  output  8  current duty register, 0..255
pwm_out  output  1  PWM drive to the H-bridge
update_strobe  output  1  single-cycle pulse when duty is rewritten
stall_fault  output  1  sticky stall indication

Behaviour:
- Reset values: duty=0, pwm_out=0, update_strobe=0, stall_fault=0, state=IDLE, PWM counter=0, stall counter=0, timeout counter=0.
- Clock and reset: one clock, clk_sys; reset is asynchronous and active-low (rst_n).
- States: IDLE, WAIT_SAMPLE, COMPUTE, APPLY, FAULT.
- IDLE: duty=0. Move to WAIT_SAMPLE when enable=1.
- WAIT_SAMPLE:
  - Timeout counter increments each cycle.
  - On meas_valid, capture meas_speed and go to COMPUTE.
  - If the counter reaches SAMPLE_TIMEOUT-1 without meas_valid, capture 0 and go to COMPUTE.
  - meas_valid and timeout in the same cycle: meas_valid wins, and its value is captured.
  - The counter clears on leaving the state.
- COMPUTE:
  - err = target - captured, as a 9-bit signed value.
  - delta = err >>> KP_SHIFT (arithmetic shift).
  - If err != 0 and delta == 0, delta = sign(err) * 1.
  - Update the stall counter in this state (see the stall rule below).
- APPLY:
  - duty <= sat(duty + delta), clamped to 0..255, using 10-bit intermediate arithmetic.
  - If target_speed == 0, duty <= 0.
  - update_strobe=1 for this cycle, with the new duty visible on the next cycle.
  - Return to WAIT_SAMPLE, or go to FAULT if the stall limit was reached.
- Latency: meas_valid in cycle t → COMPUTE in t+1 → APPLY in t+2 → new duty on the output in t+3. update_strobe is high in t+2.
- meas_valid is ignored in IDLE, COMPUTE, APPLY and FAULT. There is no queuing.
- Stall rule: a sample qualifies if captured == 0, duty >= STALL_DUTY, and target != 0.
  - A qualifying sample increments the stall counter, saturating at STALL_COUNT.
  - Any non-qualifying sample clears the counter.
  - When the counter reaches STALL_COUNT: FAULT, duty=0, stall_fault=1.
- FAULT: duty held at 0 and stall_fault held at 1 while enable=1. enable=0 → IDLE, with stall_fault and the counter cleared.
- enable deasserted in any state: IDLE on the next edge, and duty=0 on the same edge. No partial update completes.
- PWM:
  - 8-bit counter runs 0..254 and wraps, giving a 255-cycle period. It runs continuously.
  - A shadow duty is latched from duty when the counter wraps from 254 to 0.
  - pwm_out is registered: pwm_out = (cnt < shadow).
  - shadow=0 gives constant low; shadow=255 gives constant high.
  - The period never contains a glitch or a mid-period duty change.
  - On IDLE or FAULT entry, the shadow is forced to 0 immediately, so pwm_out goes low within 1 cycle.
- Reset mid-operation: all state returns to reset values asynchronously. pwm_out drops without waiting for the period to end.

Decomposition:
- Shared package motor_pkg:
  - state encoding constants
  - SPEED_W=8, DUTY_W=8, PWM_PERIOD=255
- Sub-module pwm_gen (counter, shadow register, compare; ports clk_sys, rst_n, duty, force_off, pwm_out).
- The FSM, arithmetic and stall logic stay in motor_speed_ctrl.

Test Plan:
- Reset with enable=1, target=100. Pulse meas_valid with meas=0. → update_strobe in t+2, duty=25 in t+3. A second sample, meas=0, gives duty=50.
- duty=250, target=200, meas=0, repeated. → duty saturates at 255 and never wraps. With target=0, the next APPLY gives duty=0.
- err=+1 (target=10, meas=9, KP_SHIFT=2). → duty increments by exactly 1. err=-3 gives a decrement of 1.
- No meas_valid for SAMPLE_TIMEOUT cycles. → COMPUTE runs with speed 0. meas_valid on the timeout cycle uses the meas_speed value instead.
- duty=200, target=50, meas=0 for 8 samples. → stall_fault=1 and duty=0 after the 8th sample, with pwm_out low within 1 cycle. enable low then high → fault cleared, back in WAIT_SAMPLE.
- PWM: duty changed from 64 to 128 mid-period. → the current period keeps 64 high cycles and the next period has 128. Duty 0 and 255 give constant levels. rst_n pulsed mid-period → pwm_out=0 immediately.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and widths for the motor speed controller and its PWM generator.
package motor_pkg;

  localparam int unsigned SPEED_W    = 8;
  localparam int unsigned DUTY_W     = 8;
  localparam int unsigned PWM_PERIOD = 255;
  localparam int unsigned ERR_W      = SPEED_W + 1;
  localparam int unsigned SUM_W      = DUTY_W + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_SAMPLE,
    ST_COMPUTE,
    ST_APPLY,
    ST_FAULT
  } state_t;

  // Clamp a signed duty + delta sum into 0..255.
  function automatic logic [DUTY_W-1:0] sat_duty(input logic signed [SUM_W-1:0] sum);
    if (sum[SUM_W-1])      return '0;
    else if (sum[SUM_W-2]) return '1;
    else                   return sum[DUTY_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running 255-cycle PWM with a duty shadow latched only at period wrap.
module pwm_gen
  import motor_pkg::*;
(
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] duty,
  input  logic              force_off,
  output logic              pwm_out
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);

  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] shadow;
  logic              wrap_c;

  assign wrap_c = (cnt == CNT_LAST);

  // force_off bypasses the period boundary so the bridge drops right away.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      shadow  <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt <= wrap_c ? '0 : cnt + DUTY_W'(1);
      if (force_off)   shadow <= '0;
      else if (wrap_c) shadow <= duty;
      pwm_out <= !force_off && (cnt < shadow);
    end
  end

endmodule

// File: rtl/motor_speed_ctrl.sv
// Closed-loop proportional speed controller: sample, compute, apply, with
// stall detection and an internal PWM drive.
module motor_speed_ctrl
  import motor_pkg::*;
#(
  parameter int unsigned KP_SHIFT       = 2,
  parameter int unsigned SAMPLE_TIMEOUT = 50000,
  parameter int unsigned STALL_DUTY     = 192,
  parameter int unsigned STALL_COUNT    = 8
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [SPEED_W-1:0] target_speed,
  input  logic [SPEED_W-1:0] meas_speed,
  input  logic               meas_valid,
  output logic [DUTY_W-1:0]  duty,
  output logic               pwm_out,
  output logic               update_strobe,
  output logic               stall_fault
);

  localparam int unsigned TO_W    = (SAMPLE_TIMEOUT > 1) ? $clog2(SAMPLE_TIMEOUT) : 1;
  localparam int unsigned STALL_W = $clog2(STALL_COUNT + 1);

  state_t                    state;
  logic [SPEED_W-1:0]        cap_speed;
  logic signed [ERR_W-1:0]   delta_q;
  logic [TO_W-1:0]           tout_cnt;
  logic [STALL_W-1:0]        stall_cnt;

  logic signed [ERR_W-1:0]   err_c;
  logic signed [ERR_W-1:0]   shr_c;
  logic signed [ERR_W-1:0]   delta_c;
  logic signed [SUM_W-1:0]   sum_c;
  logic                      qualify_c;
  logic                      stall_hit_c;
  logic                      force_off_c;

  // Proportional step; a nonzero error always moves duty by at least one.
  always_comb begin
    err_c   = $signed({1'b0, target_speed}) - $signed({1'b0, cap_speed});
    shr_c   = err_c >>> KP_SHIFT;
    delta_c = shr_c;
    if (err_c != '0 && shr_c == '0) delta_c = err_c[ERR_W-1] ? '1 : ERR_W'(1);
  end

  assign sum_c       = $signed({2'b00, duty}) + $signed({delta_q[ERR_W-1], delta_q});
  assign qualify_c   = (cap_speed == '0) && (duty >= DUTY_W'(STALL_DUTY)) && (target_speed != '0);
  assign stall_hit_c = (stall_cnt == STALL_W'(STALL_COUNT));

  // Kill the PWM on the same edge the controller enters IDLE or FAULT.
  assign force_off_c = !enable || (state == ST_IDLE) || (state == ST_FAULT)
                     || (state == ST_APPLY && stall_hit_c);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cap_speed     <= '0;
      delta_q       <= '0;
      tout_cnt      <= '0;
      stall_cnt     <= '0;
      duty          <= '0;
      update_strobe <= 1'b0;
      stall_fault   <= 1'b0;
    end else if (!enable) begin
      state         <= ST_IDLE;
      tout_cnt      <= '0;
      stall_cnt     <= '0;
      duty          <= '0;
      update_strobe <= 1'b0;
      stall_fault   <= 1'b0;
    end else begin
      update_strobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          duty  <= '0;
          state <= ST_WAIT_SAMPLE;
        end
        ST_WAIT_SAMPLE: begin
          if (meas_valid) begin
            cap_speed <= meas_speed;
            tout_cnt  <= '0;
            state     <= ST_COMPUTE;
          end else if (tout_cnt == TO_W'(SAMPLE_TIMEOUT - 1)) begin
            cap_speed <= '0;
            tout_cnt  <= '0;
            state     <= ST_COMPUTE;
          end else begin
            tout_cnt <= tout_cnt + TO_W'(1);
          end
        end
        ST_COMPUTE: begin
          delta_q <= delta_c;
          if (!qualify_c)        stall_cnt <= '0;
          else if (!stall_hit_c) stall_cnt <= stall_cnt + STALL_W'(1);
          update_strobe <= 1'b1;
          state         <= ST_APPLY;
        end
        ST_APPLY: begin
          if (stall_hit_c) begin
            duty        <= '0;
            stall_fault <= 1'b1;
            state       <= ST_FAULT;
          end else begin
            duty  <= (target_speed == '0) ? '0 : sat_duty(sum_c);
            state <= ST_WAIT_SAMPLE;
          end
        end
        ST_FAULT: begin
          duty        <= '0;
          stall_fault <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pwm_gen u_pwm (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .duty      (duty),
    .force_off (force_off_c),
    .pwm_out   (pwm_out)
  );

endmodule

// File: tb/tb_motor_speed_ctrl.sv
// Self-checking bench for motor_speed_ctrl: vector table with a duty
// scoreboard, plus timeout, fault, PWM and reset sequences.
module tb_motor_speed_ctrl;

  localparam int unsigned TO = 2000;
  localparam int NVEC = 27;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] target_speed = 8'd0;
  logic [7:0] meas_speed = 8'd0;
  logic       meas_valid = 1'b0;
  logic [7:0] duty;
  logic       pwm_out;
  logic       update_strobe;
  logic       stall_fault;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] tgt;
    logic [7:0] ms;
    logic [7:0] exp_duty;
    logic       exp_fault;
  } vec_t;

  vec_t       vecs [NVEC];
  logic [7:0] exp_q [$];

  motor_speed_ctrl #(
    .KP_SHIFT       (2),
    .SAMPLE_TIMEOUT (TO),
    .STALL_DUTY     (192),
    .STALL_COUNT    (8)
  ) dut (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .enable        (enable),
    .target_speed  (target_speed),
    .meas_speed    (meas_speed),
    .meas_valid    (meas_valid),
    .duty          (duty),
    .pwm_out       (pwm_out),
    .update_strobe (update_strobe),
    .stall_fault   (stall_fault)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_strobe(input int budget, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!update_strobe && lat < budget);
  endtask

  // Strobe must be present now; duty lands on the following edge.
  task automatic finish_update(input string name, input logic exp_f);
    int e;
    check({name, "/strobe"}, int'(update_strobe), 1);
    tick();
    e = -1;
    if (exp_q.size() != 0) e = int'(exp_q.pop_front());
    check({name, "/strobe_low"}, int'(update_strobe), 0);
    check({name, "/duty"}, int'(duty), e);
    check({name, "/fault"}, int'(stall_fault), int'(exp_f));
  endtask

  task automatic txn(input string name, input logic [7:0] tgt, input logic [7:0] ms,
                     input logic [7:0] exp_d, input logic exp_f);
    int lat;
    target_speed = tgt;
    meas_speed   = ms;
    meas_valid   = 1'b1;
    exp_q.push_back(exp_d);
    tick();
    meas_valid = 1'b0;
    check({name, "/early"}, int'(update_strobe), 0);
    wait_strobe(8, lat);
    check({name, "/latency"}, lat, 1);
    finish_update(name, exp_f);
  endtask

  task automatic count_high(input int n, output int hi);
    hi = 0;
    repeat (n) begin
      tick();
      hi += int'(pwm_out);
    end
  endtask

  initial begin
    int lat;
    int hi1;
    int hi2;
    int hi;
    bit started;
    bit found;

    vecs[0]  = '{8'd100, 8'd0,  8'd25,  1'b0};
    vecs[1]  = '{8'd100, 8'd0,  8'd50,  1'b0};
    vecs[2]  = '{8'd10,  8'd9,  8'd51,  1'b0};
    vecs[3]  = '{8'd10,  8'd13, 8'd50,  1'b0};
    vecs[4]  = '{8'd10,  8'd8,  8'd51,  1'b0};
    vecs[5]  = '{8'd255, 8'd0,  8'd114, 1'b0};
    vecs[6]  = '{8'd255, 8'd0,  8'd177, 1'b0};
    vecs[7]  = '{8'd255, 8'd0,  8'd240, 1'b0};
    vecs[8]  = '{8'd200, 8'd0,  8'd255, 1'b0};
    vecs[9]  = '{8'd200, 8'd0,  8'd255, 1'b0};
    vecs[10] = '{8'd0,   8'd0,  8'd0,   1'b0};
    for (int i = 0; i < 8; i++) vecs[11 + i] = '{8'd100, 8'd0, 8'(25 * (i + 1)), 1'b0};
    vecs[19] = '{8'd50, 8'd0, 8'd212, 1'b0};
    vecs[20] = '{8'd50, 8'd0, 8'd224, 1'b0};
    vecs[21] = '{8'd50, 8'd0, 8'd236, 1'b0};
    vecs[22] = '{8'd50, 8'd0, 8'd248, 1'b0};
    vecs[23] = '{8'd50, 8'd0, 8'd255, 1'b0};
    vecs[24] = '{8'd50, 8'd0, 8'd255, 1'b0};
    vecs[25] = '{8'd50, 8'd0, 8'd255, 1'b0};
    vecs[26] = '{8'd50, 8'd0, 8'd0,   1'b1};

    enable       = 1'b1;
    target_speed = 8'd100;
    repeat (3) tick();
    check("rst/duty", int'(duty), 0);
    check("rst/pwm", int'(pwm_out), 0);
    check("rst/strobe", int'(update_strobe), 0);
    check("rst/fault", int'(stall_fault), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NVEC; i++)
      txn($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].ms, vecs[i].exp_duty, vecs[i].exp_fault);

    // Stall fault: PWM off, samples ignored, enable toggle re-arms.
    tick();
    check("fault/pwm_off", int'(pwm_out), 0);
    meas_valid = 1'b1;
    tick();
    meas_valid = 1'b0;
    hi = 0;
    repeat (4) begin
      tick();
      hi += int'(update_strobe);
    end
    check("fault/ignored_strobe", hi, 0);
    check("fault/duty_held", int'(duty), 0);
    check("fault/sticky", int'(stall_fault), 1);
    enable = 1'b0;
    tick();
    check("disable/fault_clr", int'(stall_fault), 0);
    check("disable/duty", int'(duty), 0);
    enable = 1'b1;
    tick();
    txn("rearm", 8'd100, 8'd0, 8'd25, 1'b0);

    // Sample timeout substitutes speed 0.
    target_speed = 8'd100;
    exp_q.push_back(8'd50);
    wait_strobe(TO + 10, lat);
    check("timeout/latency", lat, TO + 1);
    finish_update("timeout", 1'b0);

    // meas_valid on the timeout cycle wins.
    meas_speed = 8'd96;
    repeat (TO - 1) tick();
    meas_valid = 1'b1;
    exp_q.push_back(8'd51);
    tick();
    meas_valid = 1'b0;
    wait_strobe(8, lat);
    check("to_tie/latency", lat, 1);
    finish_update("to_tie", 1'b0);

    // Mid-period duty change only takes effect at the next period.
    txn("to64", 8'd255, 8'd200, 8'd64, 1'b0);
    started = 1'b0;
    found = 1'b0;
    hi1 = 0;
    hi2 = 0;
    fork
      begin : meter
        logic prev;
        tick();
        tick();
        prev = pwm_out;
        for (int n = 0; n < 600 && !found; n++) begin
          tick();
          if (!prev && pwm_out) found = 1'b1;
          else prev = pwm_out;
        end
        started = 1'b1;
        hi1 = int'(pwm_out);
        repeat (254) begin
          tick();
          hi1 += int'(pwm_out);
        end
        count_high(255, hi2);
      end
      begin : driver
        wait (started);
        tick();
        tick();
        txn("up127", 8'd255, 8'd3, 8'd127, 1'b0);
        txn("up128", 8'd10, 8'd9, 8'd128, 1'b0);
      end
    join
    check("pwm/period_found", int'(found), 1);
    check("pwm/period_64", hi1, 64);
    check("pwm/period_128", hi2, 128);

    // Full-scale and zero duty give constant levels.
    txn("to191", 8'd255, 8'd0, 8'd191, 1'b0);
    txn("to254", 8'd255, 8'd0, 8'd254, 1'b0);
    txn("to255", 8'd255, 8'd0, 8'd255, 1'b0);
    repeat (260) tick();
    count_high(255, hi);
    check("pwm/const_high", hi, 255);
    txn("stop", 8'd0, 8'd0, 8'd0, 1'b0);
    repeat (260) tick();
    count_high(255, hi);
    check("pwm/const_low", hi, 0);

    // Asynchronous reset drops PWM mid-period.
    txn("mid63", 8'd255, 8'd0, 8'd63, 1'b0);
    found = 1'b0;
    tick();
    tick();
    for (int n = 0; n < 600 && !found; n++) begin
      tick();
      if (pwm_out) found = 1'b1;
    end
    check("areset/pwm_was_high", int'(found), 1);
    rst_n = 1'b0;
    #1;
    check("areset/pwm", int'(pwm_out), 0);
    check("areset/duty", int'(duty), 0);
    check("areset/strobe", int'(update_strobe), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
